// File: rtl/nibble_serial_adder.sv
// Adds two NIBBLES*4-bit operands one nibble per clock through an external 4-bit adder, LSB first.
// Latency: operands accepted at edge E, result valid after edge E+NIBBLES.
// Backpressure: accepts only in IDLE; result held in DONE until out_ready.
module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] in_a,
  input  logic [4*NIBBLES-1:0] in_b,
  input  logic                 in_cin,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] out_sum,
  output logic                 out_cout,
  output logic                 out_ovf,
  output logic [3:0]           add_a,
  output logic [3:0]           add_b,
  output logic                 add_cin,
  input  logic [3:0]           add_sum,
  input  logic                 add_cout
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [W-1:0]    a_sh;
  logic [W-1:0]    b_sh;
  logic [W-1:0]    sum_sh;
  logic            carry;
  logic [CW-1:0]   count;
  logic            a_msb;
  logic            b_msb;
  logic [W-1:0]    sum_nxt;

  // New sum nibble enters at the top so the first (LSB) nibble ends up at the bottom.
  if (NIBBLES == 1) begin : g_one
    assign sum_nxt = add_sum;
  end else begin : g_multi
    assign sum_nxt = {add_sum, sum_sh[W-1:4]};
  end

  // Adder stage is driven only while running; zero otherwise so idle/reset is quiet.
  always_comb begin
    add_a   = 4'd0;
    add_b   = 4'd0;
    add_cin = 1'b0;
    if (state == RUN) begin
      add_a   = a_sh[3:0];
      add_b   = b_sh[3:0];
      add_cin = carry;
    end
  end

  // Result fields come straight from the accumulated registers; meaningful only in DONE.
  assign out_sum  = sum_sh;
  assign out_cout = carry;
  assign out_ovf  = (a_msb == b_msb) && (sum_sh[W-1] != a_msb);

  // Control FSM with registered handshake flags and the serial datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      a_sh      <= '0;
      b_sh      <= '0;
      sum_sh    <= '0;
      carry     <= 1'b0;
      count     <= '0;
      a_msb     <= 1'b0;
      b_msb     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh     <= in_a;
            b_sh     <= in_b;
            carry    <= in_cin;
            count    <= '0;
            a_msb    <= in_a[W-1];
            b_msb    <= in_b[W-1];
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          sum_sh <= sum_nxt;
          carry  <= add_cout;
          a_sh   <= a_sh >> 4;
          b_sh   <= b_sh >> 4;
          count  <= count + 1'b1;
          if (count == LAST) begin
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder: a 4-nibble and a 1-nibble instance,
// each with its own external 4-bit ripple adder modelled behaviourally.
// Inputs change #1 after the rising edge; outputs are sampled at the same point.
module tb_nibble_serial_adder;

  logic clk;
  logic rst;

  // 4-nibble instance
  logic        in_valid, in_ready, in_cin, out_valid, out_ready, out_cout, out_ovf;
  logic [15:0] in_a, in_b, out_sum;
  logic [3:0]  add_a, add_b, add_sum;
  logic        add_cin, add_cout;

  // 1-nibble instance
  logic       v1_in_valid, v1_in_ready, v1_in_cin, v1_out_valid, v1_out_ready;
  logic       v1_out_cout, v1_out_ovf;
  logic [3:0] v1_in_a, v1_in_b, v1_out_sum;
  logic [3:0] v1_add_a, v1_add_b, v1_add_sum;
  logic       v1_add_cin, v1_add_cout;

  int n_cmp = 0;
  int n_bad = 0;

  nibble_serial_adder #(.NIBBLES(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_cout(out_cout), .out_ovf(out_ovf),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout)
  );

  nibble_serial_adder #(.NIBBLES(1)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(v1_in_valid), .in_ready(v1_in_ready), .in_a(v1_in_a), .in_b(v1_in_b),
    .in_cin(v1_in_cin),
    .out_valid(v1_out_valid), .out_ready(v1_out_ready), .out_sum(v1_out_sum),
    .out_cout(v1_out_cout), .out_ovf(v1_out_ovf),
    .add_a(v1_add_a), .add_b(v1_add_b), .add_cin(v1_add_cin),
    .add_sum(v1_add_sum), .add_cout(v1_add_cout)
  );

  // External 4-bit adder stages
  always_comb {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_cin};
  always_comb {v1_add_cout, v1_add_sum} = {1'b0, v1_add_a} + {1'b0, v1_add_b} + {4'd0, v1_add_cin};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one operation on the 4-nibble instance and wait for out_valid.
  // Returns edges from accept to out_valid plus per-RUN-cycle add_a and add_cin.
  task automatic op4(input logic [15:0] a, input logic [15:0] b, input logic cin,
                     output int edges, output logic [15:0] a_seq, output logic [3:0] c_seq);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    tick();
    in_valid = 1'b0;
    edges = 0;
    a_seq = '0;
    c_seq = '0;
    while (!out_valid && edges < 20) begin
      if (edges < 4) begin
        a_seq[edges*4 +: 4] = add_a;
        c_seq[edges]        = add_cin;
      end
      tick();
      edges++;
    end
  endtask

  task automatic release4();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic op1(input logic [3:0] a, input logic [3:0] b, input logic cin, output int edges);
    v1_in_valid = 1'b1;
    v1_in_a     = a;
    v1_in_b     = b;
    v1_in_cin   = cin;
    tick();
    v1_in_valid = 1'b0;
    edges = 0;
    while (!v1_out_valid && edges < 20) begin
      tick();
      edges++;
    end
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int          edges;
    logic [15:0] a_seq;
    logic [3:0]  c_seq;

    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
    vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b1, 1'b0};

    rst = 1'b1;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b0;
    v1_in_valid = 1'b0; v1_in_a = '0; v1_in_b = '0; v1_in_cin = 1'b0; v1_out_ready = 1'b0;
    #12;

    // Reset state
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_sum", {16'd0, out_sum}, 32'd0);
    chk("rst_out_cout", {31'd0, out_cout}, 32'd0);
    chk("rst_out_ovf", {31'd0, out_ovf}, 32'd0);
    chk("rst_add", {23'd0, add_a, add_b, add_cin}, 32'd0);
    chk("rst1_in_ready", {31'd0, v1_in_ready}, 32'd1);

    @(negedge clk);
    rst = 1'b0;
    tick();

    // Functional vectors
    for (int i = 0; i < 6; i++) begin
      op4(vecs[i].a, vecs[i].b, vecs[i].cin, edges, a_seq, c_seq);
      chk($sformatf("v%0d_latency", i), edges, 32'd4);
      chk($sformatf("v%0d_sum", i), {16'd0, out_sum}, {16'd0, vecs[i].sum});
      chk($sformatf("v%0d_cout", i), {31'd0, out_cout}, {31'd0, vecs[i].cout});
      chk($sformatf("v%0d_ovf", i), {31'd0, out_ovf}, {31'd0, vecs[i].ovf});
      if (i == 0) begin
        chk("v0_add_a_seq", {16'd0, a_seq}, 32'h1234);
        chk("v0_cin_seq", {28'd0, c_seq}, 32'h0);
      end
      if (i == 1) chk("v1_cin_seq", {28'd0, c_seq}, 32'hE);
      if (i < 5) release4();
    end

    // Backpressure: vecs[5] result held in DONE while inputs wiggle
    for (int k = 0; k < 10; k++) begin
      in_valid = k[0];
      in_a     = 16'h1111 * k[15:0];
      tick();
      chk($sformatf("bp%0d_valid", k), {31'd0, out_valid}, 32'd1);
      chk($sformatf("bp%0d_in_ready", k), {31'd0, in_ready}, 32'd0);
      chk($sformatf("bp%0d_sum", k), {15'd0, out_cout, out_sum}, 32'h1FFFE);
    end
    in_valid = 1'b0;
    release4();
    chk("bp_rel_in_ready", {31'd0, in_ready}, 32'd1);
    chk("bp_rel_out_valid", {31'd0, out_valid}, 32'd0);
    op4(16'h0102, 16'h0304, 1'b1, edges, a_seq, c_seq);
    chk("bp_new_latency", edges, 32'd4);
    chk("bp_new_sum", {15'd0, out_cout, out_sum}, 32'h00407);
    release4();

    // Asynchronous reset in the 2nd RUN cycle
    in_valid = 1'b1; in_a = 16'h1111; in_b = 16'h2222; in_cin = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    chk("ab_run_add_a", {28'd0, add_a}, 32'h1);
    #3;
    rst = 1'b1;
    #1;
    chk("ab_out_valid", {31'd0, out_valid}, 32'd0);
    chk("ab_in_ready", {31'd0, in_ready}, 32'd1);
    chk("ab_add", {23'd0, add_a, add_b, add_cin}, 32'd0);
    #2;
    rst = 1'b0;
    op4(16'h00FF, 16'h0001, 1'b0, edges, a_seq, c_seq);
    chk("ab_new_latency", edges, 32'd4);
    chk("ab_new_sum", {15'd0, out_cout, out_sum}, 32'h00100);
    release4();

    // Single-nibble instance (untouched so far, sitting in IDLE)
    op1(4'hF, 4'h1, 1'b0, edges);
    chk("n1a_latency", edges, 32'd1);
    chk("n1a_res", {26'd0, v1_out_cout, v1_out_ovf, v1_out_sum}, 32'h20);
    v1_out_ready = 1'b1;
    tick();
    v1_out_ready = 1'b0;
    chk("n1_rel_in_ready", {31'd0, v1_in_ready}, 32'd1);
    op1(4'h7, 4'h1, 1'b0, edges);
    chk("n1b_latency", edges, 32'd1);
    chk("n1b_res", {26'd0, v1_out_cout, v1_out_ovf, v1_out_sum}, 32'h18);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
